// File: rtl/tap_delay_line_if.sv
// Stream handshake bundle between the sample source, the tap delay line and
// the downstream dot-product stage.
interface tap_delay_line_if #(
  parameter int WIDTH = 16,
  parameter int LEN   = 8
);
  localparam int CW = $clog2(LEN + 1);

  logic                   flush;
  logic                   in_valid;
  logic [WIDTH-1:0]       in_data;
  logic                   in_ready;
  logic [LEN*WIDTH-1:0]   vec_packed;
  logic                   vec_valid;
  logic                   vec_ready;
  logic [CW-1:0]          fill_count;

  modport master (
    output flush, in_valid, in_data, vec_ready,
    input  in_ready, vec_packed, vec_valid, fill_count
  );

  modport slave (
    input  flush, in_valid, in_data, vec_ready,
    output in_ready, vec_packed, vec_valid, fill_count
  );
endinterface

// File: rtl/tap_delay_line.sv
// Shift-register tap line that presents the last LEN samples as one packed
// vector, with a valid/ready handshake toward the dot-product stage.
//
// state | meaning
// FILL  | fewer than the required samples held; vec_valid low
// OUT   | vector complete; vec_valid high until consumed, re-raised per accept
module tap_delay_line #(
  parameter int WIDTH = 16,
  parameter int LEN   = 8,
  parameter int PRIME = 0
) (
  input  logic             clk,
  input  logic             reset,
  tap_delay_line_if.slave  bus
);
  localparam int CW = $clog2(LEN + 1);

  typedef enum logic {FILL, OUT} state_t;

  state_t               state, state_next;
  logic                 vec_valid_q, vec_valid_next;
  logic [WIDTH-1:0]     taps [LEN];
  logic [CW-1:0]        count;
  logic [LEN*WIDTH-1:0] vec;
  logic                 accept;

  assign bus.in_ready   = !reset && !bus.flush && (!vec_valid_q || bus.vec_ready);
  assign accept         = bus.in_valid && bus.in_ready;
  assign bus.vec_valid  = vec_valid_q;
  assign bus.fill_count = count;
  assign bus.vec_packed = vec;

  always_comb begin
    vec = '0;
    for (int k = 0; k < LEN; k++) vec[k*WIDTH +: WIDTH] = taps[k];
  end

  always_comb begin
    state_next     = state;
    vec_valid_next = vec_valid_q;
    case (state)
      FILL: begin
        if (accept && (PRIME != 0 || count == CW'(LEN - 1))) begin
          state_next     = OUT;
          vec_valid_next = 1'b1;
        end
      end
      OUT: begin
        // A consumed vector with no replacement sample leaves a bubble but
        // the history stays complete, so the state does not fall back.
        if (accept)             vec_valid_next = 1'b1;
        else if (bus.vec_ready) vec_valid_next = 1'b0;
      end
      default: begin
        state_next     = FILL;
        vec_valid_next = 1'b0;
      end
    endcase
    if (bus.flush) begin
      state_next     = FILL;
      vec_valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      state       <= FILL;
      vec_valid_q <= 1'b0;
      count       <= '0;
      for (int k = 0; k < LEN; k++) taps[k] <= '0;
    end else begin
      state       <= state_next;
      vec_valid_q <= vec_valid_next;
      if (accept) begin
        taps[0] <= bus.in_data;
        for (int k = 1; k < LEN; k++) taps[k] <= taps[k-1];
        if (count != CW'(LEN)) count <= count + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_tap_delay_line.sv
// Drives a PRIME=0 and a PRIME=1 tap line with identical stimulus and checks
// both against a sample-history model.
module tb_tap_delay_line;
  localparam int W = 16;
  localparam int L = 8;

  logic clk;
  logic rst;
  logic fl, iv, vr;
  logic [W-1:0] id;

  int n_vec = 0;
  int n_err = 0;

  tap_delay_line_if #(.WIDTH(W), .LEN(L)) a_if ();
  tap_delay_line_if #(.WIDTH(W), .LEN(L)) b_if ();

  assign a_if.flush = fl;  assign a_if.in_valid = iv;
  assign a_if.in_data = id; assign a_if.vec_ready = vr;
  assign b_if.flush = fl;  assign b_if.in_valid = iv;
  assign b_if.in_data = id; assign b_if.vec_ready = vr;

  tap_delay_line #(.WIDTH(W), .LEN(L), .PRIME(0)) dut_a (.clk(clk), .reset(rst), .bus(a_if.slave));
  tap_delay_line #(.WIDTH(W), .LEN(L), .PRIME(1)) dut_b (.clk(clk), .reset(rst), .bus(b_if.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: newest-first sample history, number of real samples, output flag.
  logic [W-1:0] m_taps [2][L];
  int           m_cnt  [2];
  bit           m_vv   [2];

  function automatic bit model_rdy(int p);
    return !rst && !fl && (!m_vv[p] || vr);
  endfunction

  function automatic logic [L*W-1:0] model_vec(int p);
    logic [L*W-1:0] v;
    for (int k = 0; k < L; k++) v[k*W +: W] = m_taps[p][k];
    return v;
  endfunction

  task automatic model_update();
    for (int p = 0; p < 2; p++) begin
      if (rst || fl) begin
        for (int k = 0; k < L; k++) m_taps[p][k] = '0;
        m_cnt[p] = 0;
        m_vv[p]  = 0;
      end else if (iv && model_rdy(p)) begin
        for (int k = L - 1; k > 0; k--) m_taps[p][k] = m_taps[p][k-1];
        m_taps[p][0] = id;
        if (m_cnt[p] < L) m_cnt[p]++;
        m_vv[p] = (p == 1) || (m_cnt[p] >= L);
      end else if (vr) begin
        m_vv[p] = 0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  function automatic logic dut_rdy(int p);
    return (p == 1) ? b_if.in_ready : a_if.in_ready;
  endfunction
  function automatic logic dut_vv(int p);
    return (p == 1) ? b_if.vec_valid : a_if.vec_valid;
  endfunction
  function automatic logic [3:0] dut_cnt(int p);
    return (p == 1) ? b_if.fill_count : a_if.fill_count;
  endfunction
  function automatic logic [L*W-1:0] dut_vec(int p);
    return (p == 1) ? b_if.vec_packed : a_if.vec_packed;
  endfunction

  task automatic test_reset();
    rst = 1; fl = 0; iv = 1; vr = 1; id = 16'h1234;
    tick(); tick();
    for (int p = 0; p < 2; p++) begin
      n_vec++; if (dut_rdy(p) !== 1'b0) begin n_err++; $display("FAIL reset_in_ready p=%0d got %b exp 0", p, dut_rdy(p)); end
      n_vec++; if (dut_vv(p) !== 1'b0) begin n_err++; $display("FAIL reset_vec_valid p=%0d got %b exp 0", p, dut_vv(p)); end
      n_vec++; if (dut_cnt(p) !== 4'd0) begin n_err++; $display("FAIL reset_fill_count p=%0d got %0d exp 0", p, dut_cnt(p)); end
      n_vec++; if (dut_vec(p) !== '0) begin n_err++; $display("FAIL reset_vec p=%0d got %h exp 0", p, dut_vec(p)); end
    end
    rst = 0; iv = 0; #1;
    for (int p = 0; p < 2; p++) begin
      n_vec++; if (dut_rdy(p) !== 1'b1) begin n_err++; $display("FAIL post_reset_in_ready p=%0d got %b exp 1", p, dut_rdy(p)); end
    end
  endtask

  task automatic test_fill();
    vr = 1;
    for (int i = 1; i <= L; i++) begin
      id = 16'(i); iv = 1;
      tick();
      n_vec++; if (a_if.vec_valid !== (i == L)) begin n_err++; $display("FAIL fill_vec_valid sample=%0d got %b exp %b", i, a_if.vec_valid, (i == L)); end
      n_vec++; if (b_if.vec_valid !== m_vv[1]) begin n_err++; $display("FAIL fill_prime_vec_valid sample=%0d got %b exp %b", i, b_if.vec_valid, m_vv[1]); end
    end
    iv = 0;
    for (int k = 0; k < L; k++) begin
      n_vec++; if (a_if.vec_packed[k*W +: W] !== 16'(L - k)) begin n_err++; $display("FAIL fill_slice%0d got %0d exp %0d", k, a_if.vec_packed[k*W +: W], L - k); end
    end
    n_vec++; if (a_if.fill_count !== 4'(L)) begin n_err++; $display("FAIL fill_count got %0d exp %0d", a_if.fill_count, L); end
  endtask

  task automatic test_backpressure();
    logic [L*W-1:0] held;
    held = model_vec(0);
    vr = 0; iv = 1; id = 16'd9;
    for (int c = 0; c < 5; c++) begin
      #1;
      n_vec++; if (a_if.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready cycle=%0d got %b exp 0", c, a_if.in_ready); end
      tick();
      n_vec++; if (a_if.vec_packed !== held) begin n_err++; $display("FAIL bp_vec_stable cycle=%0d got %h exp %h", c, a_if.vec_packed, held); end
      n_vec++; if (a_if.vec_valid !== 1'b1) begin n_err++; $display("FAIL bp_vec_valid cycle=%0d got %b exp 1", c, a_if.vec_valid); end
    end
    vr = 1;
    tick();
    n_vec++; if (a_if.vec_packed[0 +: W] !== 16'd9) begin n_err++; $display("FAIL bp_slice0 got %0d exp 9", a_if.vec_packed[0 +: W]); end
    n_vec++; if (a_if.vec_packed[7*W +: W] !== 16'd2) begin n_err++; $display("FAIL bp_slice7 got %0d exp 2", a_if.vec_packed[7*W +: W]); end
    n_vec++; if (b_if.vec_packed !== model_vec(1)) begin n_err++; $display("FAIL bp_prime_vec got %h exp %h", b_if.vec_packed, model_vec(1)); end
  endtask

  task automatic test_stream();
    vr = 1; iv = 1;
    for (int i = 10; i <= 20; i++) begin
      id = 16'(i);
      tick();
      n_vec++; if (a_if.vec_valid !== 1'b1) begin n_err++; $display("FAIL stream_vec_valid sample=%0d got %b exp 1", i, a_if.vec_valid); end
      n_vec++; if (a_if.vec_packed[0 +: W] !== 16'(i)) begin n_err++; $display("FAIL stream_slice0 sample=%0d got %0d exp %0d", i, a_if.vec_packed[0 +: W], i); end
    end
    iv = 0;
    for (int k = 0; k < L; k++) begin
      n_vec++; if (a_if.vec_packed[k*W +: W] !== 16'(20 - k)) begin n_err++; $display("FAIL stream_slice%0d got %0d exp %0d", k, a_if.vec_packed[k*W +: W], 20 - k); end
    end
  endtask

  task automatic test_flush();
    fl = 1; iv = 1; vr = 0; id = 16'h7FFF;
    #1;
    n_vec++; if (a_if.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b exp 0", a_if.in_ready); end
    tick();
    fl = 0; iv = 0; vr = 1;
    for (int p = 0; p < 2; p++) begin
      n_vec++; if (dut_vv(p) !== 1'b0) begin n_err++; $display("FAIL flush_vec_valid p=%0d got %b exp 0", p, dut_vv(p)); end
      n_vec++; if (dut_cnt(p) !== 4'd0) begin n_err++; $display("FAIL flush_fill_count p=%0d got %0d exp 0", p, dut_cnt(p)); end
      n_vec++; if (dut_vec(p) !== '0) begin n_err++; $display("FAIL flush_vec p=%0d got %h exp 0", p, dut_vec(p)); end
    end
  endtask

  task automatic test_prime();
    logic [L*W-1:0] exp_v;
    exp_v = '0; exp_v[0 +: W] = 16'h1000;
    rst = 1; tick(); rst = 0;
    iv = 1; vr = 1; id = 16'h1000;
    tick();
    iv = 0;
    n_vec++; if (b_if.vec_valid !== 1'b1) begin n_err++; $display("FAIL prime_vec_valid got %b exp 1", b_if.vec_valid); end
    n_vec++; if (b_if.vec_packed !== exp_v) begin n_err++; $display("FAIL prime_vec got %h exp %h", b_if.vec_packed, exp_v); end
    n_vec++; if (b_if.fill_count !== 4'd1) begin n_err++; $display("FAIL prime_fill_count got %0d exp 1", b_if.fill_count); end
    n_vec++; if (a_if.vec_valid !== 1'b0) begin n_err++; $display("FAIL noprime_vec_valid got %b exp 0", a_if.vec_valid); end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] x [L];
    vr = 1; iv = 1;
    for (int i = 0; i < 5; i++) begin id = 16'($urandom); tick(); end
    iv = 0; rst = 1; tick(); rst = 0;
    x[0] = 16'h8000; x[1] = 16'h7FFF;
    for (int i = 2; i < L; i++) x[i] = 16'($urandom);
    iv = 1;
    for (int i = 0; i < L; i++) begin
      id = x[i];
      tick();
      n_vec++; if (a_if.vec_valid !== (i == L - 1)) begin n_err++; $display("FAIL rstmid_vec_valid sample=%0d got %b exp %b", i + 1, a_if.vec_valid, (i == L - 1)); end
    end
    iv = 0;
    for (int k = 0; k < L; k++) begin
      n_vec++; if (a_if.vec_packed[k*W +: W] !== x[L-1-k]) begin n_err++; $display("FAIL rstmid_slice%0d got %h exp %h", k, a_if.vec_packed[k*W +: W], x[L-1-k]); end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom % 40) == 0;
      fl  = ($urandom % 25) == 0;
      iv  = ($urandom % 4) != 0;
      vr  = ($urandom % 3) != 0;
      id  = 16'($urandom);
      #1;
      for (int p = 0; p < 2; p++) begin
        n_vec++; if (dut_rdy(p) !== model_rdy(p)) begin n_err++; $display("FAIL rand_in_ready cyc=%0d p=%0d got %b exp %b", c, p, dut_rdy(p), model_rdy(p)); end
      end
      tick();
      for (int p = 0; p < 2; p++) begin
        n_vec++; if (dut_vv(p) !== m_vv[p]) begin n_err++; $display("FAIL rand_vec_valid cyc=%0d p=%0d got %b exp %b", c, p, dut_vv(p), m_vv[p]); end
        n_vec++; if (dut_cnt(p) !== 4'(m_cnt[p])) begin n_err++; $display("FAIL rand_fill_count cyc=%0d p=%0d got %0d exp %0d", c, p, dut_cnt(p), m_cnt[p]); end
        n_vec++; if (dut_vec(p) !== model_vec(p)) begin n_err++; $display("FAIL rand_vec cyc=%0d p=%0d got %h exp %h", c, p, dut_vec(p), model_vec(p)); end
      end
    end
    rst = 0; fl = 0; iv = 0;
  endtask

  initial begin
    rst = 1; fl = 0; iv = 0; vr = 0; id = '0;
    test_reset();
    test_fill();
    test_backpressure();
    test_stream();
    test_flush();
    test_prime();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/tap_delay_line.md
TAP_DELAY_LINE -- requirements
Module: tap_delay_line

Interface
REQ-001 Parameter WIDTH, default 16: bit width of one signed Q-format sample.
REQ-002 Parameter LEN, default 8: number of taps, equal to the vector length of the downstream dot-product stage.
REQ-003 Parameter PRIME, default 0: 1 = taps treated as zero-primed, so vectors are issued from the first sample.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 flush  input  1  synchronous clear of the tap history.
REQ-007 in_valid  input  1  in_data holds a new sample x[n].
REQ-008 in_data  input  WIDTH  signed input sample.
REQ-009 in_ready  output  1  block accepts in_data this cycle.
REQ-010 vec_packed  output  LEN*WIDTH  tap vector; slice k (bits k*WIDTH+WIDTH-1 : k*WIDTH) = x[n-k], so slice 0 is the newest sample.
REQ-011 vec_valid  output  1  vec_packed is a complete vector for the downstream stage.
REQ-012 vec_ready  input  1  downstream consumes vec_packed this cycle.
REQ-013 fill_count  output  clog2(LEN+1)  number of valid samples held, saturating at LEN.

Function
REQ-014 A sample SHALL be accepted on a rising edge with in_valid=1, in_ready=1, flush=0 and reset=0.
REQ-015 On accept, the block SHALL shift slice k-1 into slice k for k=1..LEN-1, load in_data into slice 0 and discard slice LEN-1.
REQ-016 in_ready SHALL equal (!vec_valid || vec_ready) && !flush, combinationally.
  - Result: one sample per cycle under continuous vec_ready.
REQ-017 The FSM SHALL have two states, FILL and OUT.
  - FILL: vec_valid=0.
  - OUT: vec_valid=1.
REQ-018 FILL to OUT on accept when fill_count (before update) = LEN-1, or on any accept when PRIME=1.
REQ-019 OUT to FILL only on reset or flush; on a vec_ready cycle with no accept, OUT SHALL drop vec_valid to 0 and stay in OUT.
  - vec_valid SHALL re-assert on the edge of the next accept.
REQ-020 vec_valid SHALL rise on the edge that performs the completing accept (registered, latency 1 from the in_valid sample edge).
REQ-021 While vec_valid=1 and vec_ready=0, vec_packed and vec_valid SHALL be held stable (no shift, in_ready=0).
REQ-022 vec_valid=1, vec_ready=1 and accept in the same cycle SHALL shift the new sample and keep vec_valid=1, with no bubble.
REQ-023 fill_count SHALL increment by 1 per accept and saturate at LEN.
  - With PRIME=1 it still counts real samples.
REQ-024 vec_packed SHALL be driven directly from the tap registers; the block performs no arithmetic and changes no width.
REQ-025 flush=1 SHALL, on the edge:
  - zero all taps;
  - clear fill_count to 0;
  - force FILL and vec_valid=0;
  - drop any simultaneous in_valid sample.
REQ-026 flush asserted while vec_valid=1 and vec_ready=0 SHALL discard the pending vector.
REQ-027 While in FILL, vec_packed slices beyond fill_count-1 SHALL read zero.

Reset
REQ-028 reset SHALL take priority over flush and over every handshake.
REQ-029 On reset, the block SHALL:
  - zero all taps and vec_packed;
  - clear fill_count to 0;
  - clear vec_valid to 0;
  - enter FILL.
REQ-030 During reset, in_ready SHALL read 0; it SHALL be 1 (PRIME=0 or 1) on the first cycle after reset deasserts, given flush=0.
REQ-031 Reset asserted mid-stream SHALL lose the history; the next vector requires LEN fresh samples when PRIME=0.

Verification
REQ-032 Fill (LEN=8, PRIME=0, vec_ready=1): feed 1..8 on consecutive cycles.
  - vec_valid=0 after samples 1..7.
  - After sample 8: vec_valid=1, slice0=8 ... slice7=1, fill_count=8.
REQ-033 Backpressure: vector full, vec_ready=0 for 5 cycles with in_valid=1 and sample 9 presented.
  - in_ready=0 and vec_packed unchanged for all 5 cycles.
  - When vec_ready=1: 9 accepted, giving slice0=9, slice7=2.
REQ-034 Streaming: vec_ready=1 and in_valid=1 continuously for samples 9..20.
  - Exactly one vector per cycle.
  - Vector after 20 = {20,19,...,13}; no bubble.
REQ-035 Flush: flush while vec_valid=1, together with in_valid=1 and data 0x7FFF.
  - Next cycle: vec_valid=0, fill_count=0, all taps 0, 0x7FFF not stored.
REQ-036 PRIME=1: after reset, feed 0x1000.
  - Next cycle: vec_valid=1, slice0=0x1000, slices 1..7=0, fill_count=1.
REQ-037 Reset mid-stream after 5 samples, held 1 cycle; then feed 8 samples.
  - vec_valid is first 1 only after the 8th post-reset sample.
  - Signed values 0x8000/0x7FFF pass through unaltered.
